// File: rtl/obf_seqctrl_pkg.sv
// Shared widths and FSM encodings for the obfuscation sequencing controller.
package obf_seqctrl_pkg;

   localparam int OBF_PPC_WIDTH = 4;
   localparam int OBF_KEY_WIDTH = 8;

   localparam logic [0:0] OBF_SEQ_IDLE = 1'b0;
   localparam logic [0:0] OBF_SEQ_RUN  = 1'b1;

endpackage

// File: rtl/obf_seqctrl_if.sv
// Bundle of the IF-side, insngen-side and ID-side signals around obf_seqctrl.
interface obf_seqctrl_if
   import obf_seqctrl_pkg::*;
#(
   parameter int PPC_W = OBF_PPC_WIDTH,
   parameter int KEY_W = OBF_KEY_WIDTH
) ();

   logic             if_valid;
   logic [31:0]      if_insn;
   logic             if_ready;
   logic             id_freeze;
   logic             flush;
   logic             obf_en_i;
   logic [KEY_W-1:0] key_i;
   logic             key_load;
   logic [31:0]      ref_insn;
   logic [PPC_W-1:0] ppc_o;
   logic [KEY_W-1:0] obf_key;
   logic             obf_en_o;
   logic [31:0]      obf_insn;
   logic             obf_last;
   logic             obf_skip;
   logic             id_valid;
   logic [31:0]      id_insn;
   logic             seq_err;

   modport slave (
      input  if_valid, if_insn, id_freeze, flush, obf_en_i, key_i, key_load,
      input  obf_insn, obf_last, obf_skip,
      output if_ready, ref_insn, ppc_o, obf_key, obf_en_o, id_valid, id_insn, seq_err
   );

   modport master (
      output if_valid, if_insn, id_freeze, flush, obf_en_i, key_i, key_load,
      output obf_insn, obf_last, obf_skip,
      input  if_ready, ref_insn, ppc_o, obf_key, obf_en_o, id_valid, id_insn, seq_err
   );

endinterface

// File: rtl/obf_seqctrl_keyreg.sv
// Active obfuscation key plus a pending copy that is only committed at sequence boundaries.
module obf_seqctrl_keyreg #(
   parameter int KEY_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold,
   input  logic             idle,
   input  logic             seq_end,
   input  logic             key_load,
   input  logic [KEY_W-1:0] key_i,
   output logic [KEY_W-1:0] key_o
);

   logic [KEY_W-1:0] key_d, key_q;
   logic [KEY_W-1:0] pend_key_d, pend_key_q;
   logic             pend_vld_d, pend_vld_q;

   always_comb begin
      key_d      = key_q;
      pend_key_d = pend_key_q;
      pend_vld_d = pend_vld_q;
      if (!hold) begin
         // a load arriving on the boundary cycle is newer than the pending one
         if (idle || seq_end) begin
            if (key_load) begin
               key_d = key_i;
            end else if (pend_vld_q) begin
               key_d = pend_key_q;
            end
            pend_vld_d = 1'b0;
         end else if (key_load) begin
            pend_key_d = key_i;
            pend_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_q      <= '0;
         pend_key_q <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         key_q      <= key_d;
         pend_key_q <= pend_key_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   assign key_o = key_q;

endmodule

// File: rtl/obf_seqctrl.sv
// Steps the pseudo-PC through each substitution sequence and issues one registered
// sub-instruction per cycle to decode.
//   state | meaning
//   IDLE  | no sequence active; ready for a fetched instruction
//   RUN   | issuing sub-instructions of ref_insn, ppc_o advancing
module obf_seqctrl
   import obf_seqctrl_pkg::*;
#(
   parameter int PPC_W = OBF_PPC_WIDTH,
   parameter int KEY_W = OBF_KEY_WIDTH
) (
   input logic           clk,
   input logic           rst_n,
   obf_seqctrl_if.slave  bus
);

   logic [0:0]       state_d, state_q;
   logic [PPC_W-1:0] ppc_d, ppc_q;
   logic [31:0]      ref_d, ref_q;
   logic             en_d, en_q;
   logic             id_valid_d, id_valid_q;
   logic [31:0]      id_insn_d, id_insn_q;
   logic             seq_err_d, seq_err_q;
   logic [PPC_W:0]   ppc_sum;
   logic             is_idle, is_run, if_ready, accept, seq_end;

   assign is_idle  = (state_q == OBF_SEQ_IDLE);
   assign is_run   = (state_q == OBF_SEQ_RUN);
   assign if_ready = ~bus.id_freeze & ~bus.flush & (is_idle | (is_run & bus.obf_last));
   assign accept   = bus.if_valid & if_ready;
   // carry out of the extra bit flags a step past the last ppc slot
   assign ppc_sum  = {1'b0, ppc_q} + (PPC_W+1)'(1) + {{PPC_W{1'b0}}, bus.obf_skip};

   always_comb begin
      state_d    = state_q;
      ppc_d      = ppc_q;
      ref_d      = ref_q;
      en_d       = en_q;
      id_valid_d = id_valid_q;
      id_insn_d  = id_insn_q;
      seq_err_d  = seq_err_q;
      seq_end    = 1'b0;
      if (!bus.id_freeze) begin
         if (bus.flush) begin
            state_d    = OBF_SEQ_IDLE;
            ppc_d      = '0;
            id_valid_d = 1'b0;
            seq_end    = is_run;
         end else if (is_run) begin
            id_valid_d = 1'b1;
            id_insn_d  = bus.obf_insn;
            if (bus.obf_last) begin
               state_d = OBF_SEQ_IDLE;
               ppc_d   = '0;
               seq_end = 1'b1;
            end else if (ppc_sum[PPC_W]) begin
               seq_err_d = 1'b1;
               state_d   = OBF_SEQ_IDLE;
               ppc_d     = '0;
               seq_end   = 1'b1;
            end else begin
               ppc_d = ppc_sum[PPC_W-1:0];
            end
         end else begin
            id_valid_d = 1'b0;
         end
         if (accept) begin
            ref_d   = bus.if_insn;
            ppc_d   = '0;
            en_d    = bus.obf_en_i;
            state_d = OBF_SEQ_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= OBF_SEQ_IDLE;
         ppc_q      <= '0;
         ref_q      <= '0;
         en_q       <= 1'b0;
         id_valid_q <= 1'b0;
         id_insn_q  <= '0;
         seq_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ppc_q      <= ppc_d;
         ref_q      <= ref_d;
         en_q       <= en_d;
         id_valid_q <= id_valid_d;
         id_insn_q  <= id_insn_d;
         seq_err_q  <= seq_err_d;
      end
   end

   obf_seqctrl_keyreg #(.KEY_W(KEY_W)) u_keyreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold     (bus.id_freeze),
      .idle     (is_idle),
      .seq_end  (seq_end),
      .key_load (bus.key_load),
      .key_i    (bus.key_i),
      .key_o    (bus.obf_key)
   );

   assign bus.if_ready = if_ready;
   assign bus.ref_insn = ref_q;
   assign bus.ppc_o    = ppc_q;
   assign bus.obf_en_o = en_q;
   assign bus.id_valid = id_valid_q;
   assign bus.id_insn  = id_insn_q;
   assign bus.seq_err  = seq_err_q;

endmodule

// File: tb/tb_obf_seqctrl.sv
// Bench for obf_seqctrl: two instances (4-bit and 2-bit ppc) against a sequence-level model.
module tb_obf_seqctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid, id_freeze, flush, obf_en_i, key_load;
   logic [31:0] if_insn;
   logic [7:0]  key_i;
   int          lut_len;
   logic [15:0] skip_mask;
   logic        never_last;

   int n_tests = 0;
   int n_fail  = 0;

   // model state per instance: 0 = PPC_W 4, 1 = PPC_W 2
   bit          m_run[2];
   int          m_ppc[2];
   logic [31:0] m_ref[2];
   bit          m_en[2];
   logic [7:0]  m_key[2];
   logic [7:0]  m_pkey[2];
   bit          m_pflag[2];
   bit          m_err[2];
   bit          m_idv[2];
   logic [31:0] m_idi[2];
   bit          acc[2];
   int          max_ppc[2] = '{15, 3};

   always #5 clk = ~clk;

   function automatic logic gen_last(int ppc, logic en, int len, logic nl);
      return !en || (!nl && ppc >= len - 1);
   endfunction

   function automatic logic gen_skip(int ppc, logic en, logic [15:0] m);
      logic [3:0] idx;
      idx = ppc[3:0];
      return en && m[idx];
   endfunction

   function automatic logic [31:0] gen_insn(logic [31:0] r, int ppc, logic [7:0] k, logic en);
      return en ? (r ^ {4{k}} ^ (32'(ppc) << 3)) : r;
   endfunction

   obf_seqctrl_if #(.PPC_W(4), .KEY_W(8)) bus4 ();
   obf_seqctrl_if #(.PPC_W(2), .KEY_W(8)) bus2 ();

   assign bus4.if_valid  = if_valid;
   assign bus4.if_insn   = if_insn;
   assign bus4.id_freeze = id_freeze;
   assign bus4.flush     = flush;
   assign bus4.obf_en_i  = obf_en_i;
   assign bus4.key_i     = key_i;
   assign bus4.key_load  = key_load;
   assign bus4.obf_last  = gen_last(int'(bus4.ppc_o), bus4.obf_en_o, lut_len, never_last);
   assign bus4.obf_skip  = gen_skip(int'(bus4.ppc_o), bus4.obf_en_o, skip_mask);
   assign bus4.obf_insn  = gen_insn(bus4.ref_insn, int'(bus4.ppc_o), bus4.obf_key, bus4.obf_en_o);

   assign bus2.if_valid  = if_valid;
   assign bus2.if_insn   = if_insn;
   assign bus2.id_freeze = id_freeze;
   assign bus2.flush     = flush;
   assign bus2.obf_en_i  = obf_en_i;
   assign bus2.key_i     = key_i;
   assign bus2.key_load  = key_load;
   assign bus2.obf_last  = gen_last(int'(bus2.ppc_o), bus2.obf_en_o, lut_len, never_last);
   assign bus2.obf_skip  = gen_skip(int'(bus2.ppc_o), bus2.obf_en_o, skip_mask);
   assign bus2.obf_insn  = gen_insn(bus2.ref_insn, int'(bus2.ppc_o), bus2.obf_key, bus2.obf_en_o);

   obf_seqctrl #(.PPC_W(4), .KEY_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   obf_seqctrl #(.PPC_W(2), .KEY_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear(input int d);
      m_run[d] = 0; m_ppc[d] = 0; m_ref[d] = '0; m_en[d] = 0; m_key[d] = '0;
      m_pkey[d] = '0; m_pflag[d] = 0; m_err[d] = 0; m_idv[d] = 0; m_idi[d] = '0;
   endtask

   // Called at a negedge with inputs already driven; advances one clock and checks.
   task automatic cycle();
      logic gl, gs, rdy, was_run, ends;
      logic [31:0] gi;
      #1;
      for (int d = 0; d < 2; d++) begin
         gl  = gen_last(m_ppc[d], m_en[d], lut_len, never_last);
         gs  = gen_skip(m_ppc[d], m_en[d], skip_mask);
         gi  = gen_insn(m_ref[d], m_ppc[d], m_key[d], m_en[d]);
         rdy = !id_freeze && !flush && (!m_run[d] || gl);
         chk($sformatf("ready%0d", d), (d == 0) ? 32'(bus4.if_ready) : 32'(bus2.if_ready), 32'(rdy));
         acc[d] = rst_n && rdy && if_valid;
         if (!rst_n) begin
            model_clear(d);
         end else if (!id_freeze) begin
            was_run = m_run[d];
            ends    = 0;
            if (flush) begin
               ends = m_run[d]; m_run[d] = 0; m_ppc[d] = 0; m_idv[d] = 0;
            end else if (m_run[d]) begin
               m_idv[d] = 1; m_idi[d] = gi; ends = 1; m_run[d] = 0;
               if (gl) begin
                  m_ppc[d] = 0;
               end else if (m_ppc[d] + 1 + int'(gs) > max_ppc[d]) begin
                  m_err[d] = 1; m_ppc[d] = 0;
               end else begin
                  m_ppc[d] = m_ppc[d] + 1 + int'(gs); m_run[d] = 1; ends = 0;
               end
            end else begin
               m_idv[d] = 0;
            end
            if (!was_run || ends) begin
               if (key_load) m_key[d] = key_i;
               else if (m_pflag[d]) m_key[d] = m_pkey[d];
               m_pflag[d] = 0;
            end else if (key_load) begin
               m_pkey[d] = key_i; m_pflag[d] = 1;
            end
            if (acc[d]) begin
               m_ref[d] = if_insn; m_ppc[d] = 0; m_en[d] = obf_en_i; m_run[d] = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("id_valid0", 32'(bus4.id_valid), 32'(m_idv[0]));
      chk("id_insn0",  bus4.id_insn,       m_idi[0]);
      chk("ppc0",      32'(bus4.ppc_o),    32'(m_ppc[0]));
      chk("key0",      32'(bus4.obf_key),  32'(m_key[0]));
      chk("en0",       32'(bus4.obf_en_o), 32'(m_en[0]));
      chk("err0",      32'(bus4.seq_err),  32'(m_err[0]));
      chk("ref0",      bus4.ref_insn,      m_ref[0]);
      chk("id_valid1", 32'(bus2.id_valid), 32'(m_idv[1]));
      chk("id_insn1",  bus2.id_insn,       m_idi[1]);
      chk("ppc1",      32'(bus2.ppc_o),    32'(m_ppc[1]));
      chk("key1",      32'(bus2.obf_key),  32'(m_key[1]));
      chk("en1",       32'(bus2.obf_en_o), 32'(m_en[1]));
      chk("err1",      32'(bus2.seq_err),  32'(m_err[1]));
      chk("ref1",      bus2.ref_insn,      m_ref[1]);
      @(negedge clk);
   endtask

   task automatic pulse_accept(input logic [31:0] insn);
      if_valid = 1'b1; if_insn = insn; obf_en_i = 1'b1;
      cycle();
      if_valid = 1'b0;
   endtask

   initial begin
      int cnt, cnt2, first, lastv, n_acc;
      rst_n = 1'b0; if_valid = 1'b0; if_insn = '0; id_freeze = 1'b0; flush = 1'b0;
      obf_en_i = 1'b1; key_i = '0; key_load = 1'b0;
      lut_len = 1; skip_mask = '0; never_last = 1'b0;
      model_clear(0); model_clear(1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      cycle();
      chk("rst_id_valid", 32'(bus4.id_valid), 32'd0);
      chk("rst_ppc",      32'(bus4.ppc_o),    32'd0);
      chk("rst_key",      32'(bus4.obf_key),  32'd0);
      chk("rst_err",      32'(bus2.seq_err),  32'd0);
      rst_n = 1'b1;
      cycle();

      // 3-slot sequence, one instruction
      lut_len = 3;
      pulse_accept(32'h1234_5678);
      cnt = 0;
      repeat (6) begin
         cycle();
         if (bus4.id_valid) cnt++;
      end
      chk("seq3_issues", 32'(cnt), 32'd3);

      // two back-to-back 2-slot sequences, no bubble
      lut_len = 2; n_acc = 0; cnt = 0; first = -1; lastv = -1;
      for (int i = 0; i < 10; i++) begin
         if_valid = (n_acc < 2);
         if_insn  = $urandom;
         cycle();
         if (acc[0]) n_acc++;
         if (bus4.id_valid) begin
            cnt++;
            if (first < 0) first = i;
            lastv = i;
         end
      end
      if_valid = 1'b0;
      chk("b2b_accepts", 32'(n_acc), 32'd2);
      chk("b2b_issues",  32'(cnt), 32'd4);
      chk("b2b_span",    32'(lastv - first + 1), 32'd4);

      // skip at ppc 0 jumps straight to ppc 2
      lut_len = 3; skip_mask = 16'h0001;
      pulse_accept(32'hCAFE_0001);
      cycle();
      chk("skip_ppc", 32'(bus4.ppc_o), 32'd2);
      cnt = 1;
      repeat (4) begin
         cycle();
         if (bus4.id_valid) cnt++;
      end
      chk("skip_issues", 32'(cnt), 32'd2);
      skip_mask = '0;

      // never-last LUT: overflow on both widths
      never_last = 1'b1;
      pulse_accept(32'hDEAD_BEEF);
      cnt = 0; cnt2 = 0;
      repeat (20) begin
         cycle();
         if (bus4.id_valid) cnt++;
         if (bus2.id_valid) cnt2++;
      end
      chk("ovf_issues_w2", 32'(cnt2), 32'd4);
      chk("ovf_issues_w4", 32'(cnt), 32'd16);
      chk("ovf_err_w2", 32'(bus2.seq_err), 32'd1);
      never_last = 1'b0;
      repeat (3) cycle();
      chk("ovf_sticky", 32'(bus2.seq_err), 32'd1);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      chk("ovf_cleared", 32'(bus2.seq_err), 32'd0);

      // key load mid-sequence is deferred to the sequence end
      lut_len = 3;
      pulse_accept(32'h0F0F_0F0F);
      key_load = 1'b1; key_i = 8'hA5;
      cycle();
      key_load = 1'b0; key_i = 8'h3C;
      cycle();
      chk("key_deferred", 32'(bus4.obf_key), 32'd0);
      repeat (3) cycle();
      chk("key_applied", 32'(bus4.obf_key), 32'hA5);
      pulse_accept(32'h7777_0000);
      chk("key_newseq_ppc", 32'(bus4.ppc_o), 32'd0);
      chk("key_newseq", 32'(bus4.obf_key), 32'hA5);
      repeat (4) cycle();

      // freeze pulse then flush at ppc 1
      lut_len = 4;
      pulse_accept(32'hABCD_0123);
      cycle();
      id_freeze = 1'b1;
      cycle();
      chk("frz_ppc", 32'(bus4.ppc_o), 32'd1);
      id_freeze = 1'b0; flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_idv", 32'(bus4.id_valid), 32'd0);
      chk("flush_ppc", 32'(bus4.ppc_o), 32'd0);
      cycle();
      chk("flush_idle", 32'(bus4.id_valid), 32'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 40 == 0) begin
            lut_len    = $urandom_range(1, 6);
            skip_mask  = 16'($urandom);
            never_last = ($urandom_range(0, 9) == 0);
         end
         if_valid  = $urandom_range(0, 1) != 0;
         if_insn   = $urandom;
         id_freeze = ($urandom_range(0, 7) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         obf_en_i  = ($urandom_range(0, 3) != 0);
         key_load  = ($urandom_range(0, 7) == 0);
         key_i     = 8'($urandom);
         rst_n     = ($urandom_range(0, 299) != 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
